// File: rtl/seq_mult_8bit_if.sv
// Handshake and data bundle between a requester and the sequential 8x8 multiplier.
// The requester drives operands and start; the multiplier returns status and the product.
interface seq_mult_8bit_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier around a single 8-bit adder.
// One conditional add plus right shift per clock, 16-bit product after eight iterations.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module seq_mult_8bit (
    input  logic            clk,
    input  logic            rst,
    seq_mult_8bit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [7:0]  mcand, mcand_n;
    logic [7:0]  mq, mq_n;
    logic [2:0]  count, count_n;
    logic [15:0] product, product_n;
    logic        busy, done;
    logic [7:0]  sum;
    logic        cout;

    // The 9-bit accumulator's top bit is always zero once shifted, so only
    // the low eight bits are stored; the carry is folded in during the shift.
    logic [7:0]  acc, acc_n;

    adder_8bit u_adder (
        .a    (acc),
        .b    (mcand),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_n   = state;
        mcand_n   = mcand;
        mq_n      = mq;
        acc_n     = acc;
        count_n   = count;
        product_n = product;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    mcand_n = bus.a;
                    mq_n    = bus.b;
                    acc_n   = 8'h00;
                    count_n = 3'd0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (mq[0]) begin
                    acc_n = {cout, sum[7:1]};
                    mq_n  = {sum[0], mq[7:1]};
                end else begin
                    acc_n = {1'b0, acc[7:1]};
                    mq_n  = {acc[0], mq[7:1]};
                end
                count_n = count + 3'd1;
                if (count == 3'd7) begin
                    state_n   = DONE;
                    product_n = {acc_n, mq_n};
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= 8'h00;
            mq      <= 8'h00;
            acc     <= 8'h00;
            count   <= 3'd0;
            product <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            mcand   <= mcand_n;
            mq      <= mq_n;
            acc     <= acc_n;
            count   <= count_n;
            product <= product_n;
            busy    <= (state_n != IDLE);
            done    <= (state_n == DONE);
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
endmodule

// File: tb/tb_seq_mult_8bit.sv
// Scoreboard bench for seq_mult_8bit: stimulus queues hand-computed products,
// a monitor pops and compares them whenever done is seen.
module tb_seq_mult_8bit;
    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;
    logic [15:0] sbq[$];

    seq_mult_8bit_if bus ();

    seq_mult_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                logic [15:0] exp;
                exp = sbq.pop_front();
                checkOutput("product", {16'h0, bus.product}, {16'h0, exp});
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic [15:0] exp, input bit track);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (track) sbq.push_back(exp);
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.done && edges < 20);
        if (!bus.done) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic runOne(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
        int edges;
        applyStimulus(av, bv, exp, 1'b1);
        checkOutput("busy_after_accept", {31'h0, bus.busy}, 1);
        waitDone(edges);
        checkOutput("done_latency", edges, 8);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", {31'h0, bus.done}, 0);
        checkOutput("busy_fall", {31'h0, bus.busy}, 0);
        checkOutput("product_hold", {16'h0, bus.product}, {16'h0, exp});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;
        checkCount = 0;
        passCount  = 0;
        bus.start  = 1'b0;
        bus.a      = 8'h00;
        bus.b      = 8'h00;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'h0, bus.busy}, 0);
        checkOutput("reset_done", {31'h0, bus.done}, 0);
        checkOutput("reset_product", {16'h0, bus.product}, 0);
        @(negedge clk);
        rst = 1'b0;

        runOne(8'd9, 8'd254, 16'h08EE);

        // Start held high: the second request is only taken once back in IDLE.
        @(negedge clk);
        bus.a     = 8'd252;
        bus.b     = 8'd10;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        sbq.push_back(16'h09D8);
        bus.a = 8'd255;
        bus.b = 8'd255;
        waitDone(edges);
        checkOutput("b2b_latency", edges, 8);
        @(posedge clk);
        #1;
        checkOutput("b2b_idle_gap", {31'h0, bus.busy}, 0);
        @(posedge clk);
        #1;
        checkOutput("b2b_second_accept", {31'h0, bus.busy}, 1);
        bus.start = 1'b0;
        sbq.push_back(16'hFE01);
        waitDone(edges);
        checkOutput("b2b_second_latency", edges, 8);
        @(posedge clk);
        #1;

        runOne(8'd0, 8'hA5, 16'h0000);
        runOne(8'hA5, 8'd0, 16'h0000);
        runOne(8'd1, 8'h80, 16'h0080);

        // Operand changes and a start pulse during RUN must be ignored.
        applyStimulus(8'd7, 8'd9, 16'd63, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(edges);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("stable_product_hold", {16'h0, bus.product}, 16'd63);
        checkOutput("stable_idle", {31'h0, bus.busy}, 0);

        // Reset in the middle of RUN clears outputs at once.
        applyStimulus(8'd200, 8'd200, 16'h0000, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {31'h0, bus.busy}, 0);
        checkOutput("midrst_done", {31'h0, bus.done}, 0);
        checkOutput("midrst_product", {16'h0, bus.product}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        runOne(8'd3, 8'd5, 16'h000F);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
